f_min_select: RTL and testbench

F_MIN_SELECT -- requirements
Module: f_min_select

---
 rtl/f_min_select.sv | 108 ++++++++++
 tb/tb_f_min_select.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/f_min_select.sv
// Streaming minimum search over groups of N IEEE-754 doubles.
// Reports the group minimum and its arrival index one cycle after the Nth sample.
module f_min_select #(
  parameter  int N         = 8,
  localparam int IDX_WIDTH = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [63:0]          F_value,
  input  logic                 F_value_tvalid,
  input  logic                 group_clr,
  output logic [63:0]          best_value,
  output logic [IDX_WIDTH-1:0] best_idx,
  output logic                 best_tvalid,
  output logic                 busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);
  localparam logic [63:0]          SIGN_BIT = 64'h8000_0000_0000_0000;

  state_t               state, state_nxt;
  logic [IDX_WIDTH-1:0] cnt;
  logic [IDX_WIDTH-1:0] run_idx;
  logic [63:0]          run_best;

  // Order-preserving integer key; -0.0 folded onto +0.0 so the two tie.
  function automatic logic [63:0] fkey(input logic [63:0] b);
    logic [63:0] n;
    n = (b == SIGN_BIT) ? '0 : b;
    return n[63] ? ~n : (n ^ SIGN_BIT);
  endfunction

  function automatic logic is_nan(input logic [63:0] b);
    return (&b[62:52]) && (|b[51:0]);
  endfunction

  logic sample_nan;
  logic best_nan;
  logic take;
  logic last_sample;

  always_comb begin
    sample_nan  = is_nan(F_value);
    best_nan    = is_nan(run_best);
    take        = !sample_nan && (best_nan || (fkey(F_value) < fkey(run_best)));
    last_sample = (state == ACCUM) && (cnt == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (group_clr) begin
      state_nxt = IDLE;
    end else if (F_value_tvalid) begin
      case (state)
        IDLE:    state_nxt = ACCUM;
        ACCUM:   if (last_sample) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      run_best    <= '0;
      run_idx     <= '0;
      best_value  <= '0;
      best_idx    <= '0;
      best_tvalid <= 1'b0;
    end else begin
      best_tvalid <= 1'b0;
      if (group_clr) begin
        cnt <= '0;
      end else if (F_value_tvalid) begin
        if (state == IDLE) begin
          run_best <= F_value;
          run_idx  <= '0;
          cnt      <= IDX_WIDTH'(1);
        end else if (last_sample) begin
          // Final compare goes straight to the outputs; the running best is dead.
          best_value  <= take ? F_value : run_best;
          best_idx    <= take ? cnt : run_idx;
          best_tvalid <= 1'b1;
          cnt         <= '0;
        end else begin
          if (take) begin
            run_best <= F_value;
            run_idx  <= cnt;
          end
          cnt <= cnt + IDX_WIDTH'(1);
        end
      end
    end
  end

  assign busy = (state == ACCUM);

endmodule

// File: tb/tb_f_min_select.sv
// Directed plus randomized checks of f_min_select (N=4) against a reference model
// that orders samples by their real-number value.
module tb_f_min_select;

  localparam int N  = 4;
  localparam int IW = $clog2(N) + 1;

  localparam logic [63:0] P2  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] PH  = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] P1  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] P3  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] M1  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] M2  = 64'hC000_0000_0000_0000;
  localparam logic [63:0] PZ  = 64'h0000_0000_0000_0000;
  localparam logic [63:0] MZ  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] QN  = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] P5  = 64'h4014_0000_0000_0000;
  localparam logic [63:0] P4  = 64'h4010_0000_0000_0000;
  localparam logic [63:0] PI  = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] MI  = 64'hFFF0_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   F_value = '0;
  logic          F_value_tvalid = 1'b0;
  logic          group_clr = 1'b0;
  logic [63:0]   best_value;
  logic [IW-1:0] best_idx;
  logic          best_tvalid;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] grp[N];
  int          gcnt = 0;
  logic        exp_tv = 1'b0;
  logic [63:0] exp_val = '0;
  logic [63:0] exp_idx = '0;
  int          pulses = 0;

  f_min_select #(.N(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .F_value        (F_value),
    .F_value_tvalid (F_value_tvalid),
    .group_clr      (group_clr),
    .best_value     (best_value),
    .best_idx       (best_idx),
    .best_tvalid    (best_tvalid),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (best_tvalid) pulses++;

  function automatic logic nan_of(input logic [63:0] b);
    return (b[62:52] == 11'h7FF) && (b[51:0] != 52'h0);
  endfunction

  // Group minimum by real value: NaNs never win over numbers, ties keep the earliest.
  task automatic ref_min();
    int bi;
    bi = 0;
    for (int i = 1; i < N; i++) begin
      if (!nan_of(grp[i])) begin
        if (nan_of(grp[bi])) bi = i;
        else if ($bitstoreal(grp[i]) < $bitstoreal(grp[bi])) bi = i;
      end
    end
    exp_val = grp[bi];
    exp_idx = 64'(bi);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_tvalid"}, 64'(best_tvalid), 64'(exp_tv));
    chk({tag, "_value"},  best_value, exp_val);
    chk({tag, "_idx"},    64'(best_idx), exp_idx);
    chk({tag, "_busy"},   64'(busy), 64'(gcnt != 0));
  endtask

  task automatic cyc(input string tag, input logic v, input logic [63:0] d, input logic c);
    @(negedge clk);
    F_value_tvalid = v;
    F_value        = d;
    group_clr      = c;
    @(posedge clk);
    exp_tv = 1'b0;
    if (c) begin
      gcnt = 0;
    end else if (v) begin
      grp[gcnt] = d;
      gcnt++;
      if (gcnt == N) begin
        ref_min();
        exp_tv = 1'b1;
        gcnt   = 0;
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, 1'b0, 64'h0, 1'b0);
  endtask

  function automatic logic [63:0] rand_val();
    logic [63:0] pool[12];
    pool = '{P2, PH, P1, P3, M1, M2, PZ, MZ, QN, PI, MI, 64'hFFF0_0000_0000_0001};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 11)];
    return {$urandom(), $urandom()};
  endfunction

  int p_before;

  initial begin
    #3;
    chk("rst_tvalid", 64'(best_tvalid), 64'h0);
    chk("rst_value",  best_value, 64'h0);
    chk("rst_idx",    64'(best_idx), 64'h0);
    chk("rst_busy",   64'(busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc("g031", 1'b1, P2, 1'b0);
    cyc("g031", 1'b1, PH, 1'b0);
    cyc("g031", 1'b1, P1, 1'b0);
    cyc("g031", 1'b1, P3, 1'b0);
    idle_cyc("g031_out");
    chk("g031_value_abs", best_value, PH);
    chk("g031_idx_abs", 64'(best_idx), 64'd1);
    idle_cyc("g031_hold");

    cyc("g032a", 1'b1, M1, 1'b0);
    cyc("g032a", 1'b1, M2, 1'b0);
    cyc("g032a", 1'b1, PZ, 1'b0);
    cyc("g032a", 1'b1, MZ, 1'b0);
    idle_cyc("g032a_out");
    chk("g032a_value_abs", best_value, M2);
    cyc("g032b", 1'b1, PZ, 1'b0);
    cyc("g032b", 1'b1, MZ, 1'b0);
    cyc("g032b", 1'b1, P1, 1'b0);
    cyc("g032b", 1'b1, P1, 1'b0);
    idle_cyc("g032b_out");
    chk("g032b_idx_abs", 64'(best_idx), 64'd0);

    cyc("g033a", 1'b1, QN, 1'b0);
    cyc("g033a", 1'b1, P5, 1'b0);
    cyc("g033a", 1'b1, QN, 1'b0);
    cyc("g033a", 1'b1, P4, 1'b0);
    idle_cyc("g033a_out");
    chk("g033a_idx_abs", 64'(best_idx), 64'd3);
    cyc("g033b", 1'b1, 64'h7FF8_0000_0000_0001, 1'b0);
    cyc("g033b", 1'b1, QN, 1'b0);
    cyc("g033b", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    cyc("g033b", 1'b1, QN, 1'b0);
    idle_cyc("g033b_out");
    chk("g033b_idx_abs", 64'(best_idx), 64'd0);

    cyc("g034", 1'b1, P3, 1'b0);
    cyc("g034", 1'b1, P2, 1'b0);
    cyc("g034", 1'b1, MI, 1'b0);
    cyc("g034", 1'b1, PI, 1'b0);
    cyc("g034", 1'b1, M2, 1'b0);
    cyc("g034", 1'b1, M1, 1'b0);
    cyc("g034", 1'b1, P1, 1'b0);
    cyc("g034", 1'b1, M2, 1'b0);
    idle_cyc("g034_out");
    chk("g034_idx_abs", 64'(best_idx), 64'd0);

    p_before = pulses;
    cyc("g035", 1'b1, M2, 1'b0);
    cyc("g035", 1'b1, M1, 1'b0);
    cyc("g035", 1'b0, 64'h0, 1'b1);
    cyc("g035", 1'b1, P3, 1'b0);
    cyc("g035", 1'b1, P2, 1'b0);
    cyc("g035", 1'b1, P5, 1'b0);
    cyc("g035", 1'b1, P4, 1'b0);
    idle_cyc("g035_out");
    chk("g035_pulses", 64'(pulses - p_before), 64'd1);
    chk("g035_value_abs", best_value, P2);
    cyc("g035b", 1'b1, M1, 1'b0);
    cyc("g035b", 1'b1, M1, 1'b0);
    cyc("g035b", 1'b1, M1, 1'b0);
    cyc("g035b", 1'b1, MI, 1'b1);
    idle_cyc("g035b_out");
    chk("g035b_value_abs", best_value, P2);

    p_before = pulses;
    cyc("g036", 1'b1, M1, 1'b0);
    cyc("g036", 1'b1, M2, 1'b0);
    cyc("g036", 1'b1, P1, 1'b0);
    @(negedge clk);
    F_value_tvalid = 1'b1;
    F_value        = MI;
    #2 rst_n = 1'b0;
    #1;
    gcnt = 0; exp_tv = 1'b0; exp_val = '0; exp_idx = '0;
    check_outs("g036_rst");
    repeat (2) @(posedge clk);
    #1;
    check_outs("g036_rst_hold");
    chk("g036_no_pulse", 64'(pulses - p_before), 64'd0);
    @(negedge clk);
    F_value_tvalid = 1'b0;
    rst_n = 1'b1;
    cyc("g036", 1'b1, P3, 1'b0);
    cyc("g036", 1'b1, PH, 1'b0);
    cyc("g036", 1'b1, P4, 1'b0);
    cyc("g036", 1'b1, P2, 1'b0);
    idle_cyc("g036_out");
    chk("g036_pulses", 64'(pulses - p_before), 64'd1);
    chk("g036_idx_abs", 64'(best_idx), 64'd1);

    for (int k = 0; k < 400; k++) begin
      logic v, c;
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 29) == 0);
      cyc("rand", v, rand_val(), c);
    end
    idle_cyc("rand_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
